// File: rtl/seg_pkg.sv
// Shared types and 7-segment constants for the arbitrated SEG path.
package seg_pkg;

  typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} owner_t;
  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;
  typedef logic [1:0] level_t;

  localparam logic [7:0] APAGADO = 8'h00;
  localparam logic [7:0] ZERO    = 8'h3F;
  localparam logic [7:0] UM      = 8'h06;
  localparam logic [7:0] DOIS    = 8'h5B;

  function automatic logic [7:0] encode_level(input level_t level);
    logic [7:0] pattern;
    case (level)
      2'b01:   pattern = ZERO;
      2'b10:   pattern = UM;
      2'b11:   pattern = DOIS;
      default: pattern = APAGADO;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/level_to_seg.sv
// Combinational 2-bit sensor level to 7-segment pattern encoder.
module level_to_seg
  import seg_pkg::*;
(
  input  level_t     level,
  output logic [7:0] pattern
);

  assign pattern = encode_level(level);

endmodule

// File: rtl/seg_share_arbiter.sv
// Round-robin arbiter sharing one 7-segment display between sensors A and B,
// with a minimum hold per grant and a registered segment pattern.
module seg_share_arbiter
  import seg_pkg::*;
#(
  parameter int NBITS_SEG   = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                 clk_2,
  input  logic                 rst_n,
  input  logic                 req_a,
  input  logic                 req_b,
  input  logic [1:0]           sensor_a,
  input  logic [1:0]           sensor_b,
  output logic [NBITS_SEG-1:0] seg,
  output logic                 gnt_a,
  output logic                 gnt_b,
  output logic                 busy,
  output logic [7:0]           nswitch
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  state_t         state, next_state;
  owner_t         last_owner;
  logic [CW-1:0]  hold_cnt;
  level_t         sel_level;
  logic [7:0]     sel_pattern;
  logic [NBITS_SEG-1:0] seg_next;
  logic           grant_start;

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_a && req_b)
          next_state = (last_owner == OWN_A) ? GNT_B : GNT_A;
        else if (req_a)
          next_state = GNT_A;
        else if (req_b)
          next_state = GNT_B;
      end
      GNT_A: begin
        if (!req_a)
          next_state = req_b ? GNT_B : IDLE;
        else if (req_b && hold_cnt == HOLD_LAST)
          next_state = GNT_B;
      end
      GNT_B: begin
        if (!req_b)
          next_state = req_a ? GNT_A : IDLE;
        else if (req_a && hold_cnt == HOLD_LAST)
          next_state = GNT_A;
      end
      default: next_state = IDLE;
    endcase
  end

  assign grant_start = (next_state != state) && (next_state != IDLE);

  // The pattern is taken from whoever will own the display after this edge.
  always_comb begin
    sel_level = 2'b00;
    if (next_state == GNT_A)
      sel_level = sensor_a;
    else if (next_state == GNT_B)
      sel_level = sensor_b;
  end

  level_to_seg u_level_to_seg (
    .level   (sel_level),
    .pattern (sel_pattern)
  );

  always_comb begin
    seg_next = NBITS_SEG'(sel_pattern);
    if (next_state == IDLE)
      seg_next = NBITS_SEG'(APAGADO);
  end

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_owner <= OWN_B;
      hold_cnt   <= '0;
      nswitch    <= 8'd0;
      seg        <= '0;
    end else begin
      state <= next_state;
      seg   <= seg_next;
      if (grant_start) begin
        hold_cnt   <= '0;
        nswitch    <= nswitch + 8'd1;
        last_owner <= (next_state == GNT_A) ? OWN_A : OWN_B;
      end else if (next_state == IDLE) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HOLD_LAST) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  assign gnt_a = (state == GNT_A);
  assign gnt_b = (state == GNT_B);
  assign busy  = gnt_a | gnt_b;

endmodule

// File: tb/tb_seg_share_arbiter.sv
// Directed bench for seg_share_arbiter with HOLD_CYCLES=4.
module tb_seg_share_arbiter;

  logic       clk_2 = 1'b0;
  logic       rst_n;
  logic       req_a, req_b;
  logic [1:0] sensor_a, sensor_b;
  logic [7:0] seg;
  logic       gnt_a, gnt_b, busy;
  logic [7:0] nswitch;

  int errors = 0;
  int checks = 0;

  seg_share_arbiter #(.NBITS_SEG(8), .HOLD_CYCLES(4)) dut (
    .clk_2    (clk_2),
    .rst_n    (rst_n),
    .req_a    (req_a),
    .req_b    (req_b),
    .sensor_a (sensor_a),
    .sensor_b (sensor_b),
    .seg      (seg),
    .gnt_a    (gnt_a),
    .gnt_b    (gnt_b),
    .busy     (busy),
    .nswitch  (nswitch)
  );

  always #5 clk_2 = ~clk_2;

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_a = 1'b1; req_b = 1'b0;
    sensor_a = 2'b01; sensor_b = 2'b00;
    repeat (3) tick();
    checks++;
    if ({seg, gnt_a, gnt_b, busy, nswitch} !== {8'h00, 3'b000, 8'd0}) begin
      errors++;
      $display("[TB] FAIL reset_hold seg=%h gnt=%b%b busy=%b nsw=%0d exp seg=00 gnt=00 busy=0 nsw=0",
               seg, gnt_a, gnt_b, busy, nswitch);
    end
    @(negedge clk_2);
    rst_n = 1'b1;
    tick();
    checks++;
    if ({seg, gnt_a, gnt_b, nswitch} !== {8'h3F, 2'b10, 8'd1}) begin
      errors++;
      $display("[TB] FAIL reset_first_grant seg=%h gnt=%b%b nsw=%0d exp seg=3f gnt=10 nsw=1",
               seg, gnt_a, gnt_b, nswitch);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_gnt;
    logic [7:0] exp_seg, exp_nsw;
    rst_n = 1'b0; req_a = 1'b1; req_b = 1'b1;
    sensor_a = 2'b01; sensor_b = 2'b10;
    #2;
    @(negedge clk_2);
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_gnt = (((i - 1) / 4) % 2 == 0) ? 2'b10 : 2'b01;
      exp_seg = (exp_gnt == 2'b10) ? 8'h3F : 8'h06;
      exp_nsw = 8'((i - 1) / 4 + 1);
      checks++;
      if ({gnt_a, gnt_b, seg, nswitch} !== {exp_gnt, exp_seg, exp_nsw}) begin
        errors++;
        $display("[TB] FAIL rr_cycle%0d gnt=%b%b seg=%h nsw=%0d exp gnt=%b seg=%h nsw=%0d",
                 i, gnt_a, gnt_b, seg, nswitch, exp_gnt, exp_seg, exp_nsw);
      end
    end
  endtask

  // Entered with GNT_A held at hold terminal and nswitch=3.
  task automatic test_seg_follow();
    logic [1:0] steps [3];
    logic [7:0] pats  [3];
    steps = '{2'b01, 2'b10, 2'b11};
    pats  = '{8'h3F, 8'h06, 8'h5B};
    req_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sensor_a = steps[i];
      tick();
      checks++;
      if ({gnt_a, seg} !== {1'b1, pats[i]}) begin
        errors++;
        $display("[TB] FAIL seg_follow%0d gnt_a=%b seg=%h exp gnt_a=1 seg=%h",
                 i, gnt_a, seg, pats[i]);
      end
    end
    repeat (10) tick();
    checks++;
    if ({gnt_a, gnt_b, nswitch} !== {2'b10, 8'd3}) begin
      errors++;
      $display("[TB] FAIL long_hold gnt=%b%b nsw=%0d exp gnt=10 nsw=3", gnt_a, gnt_b, nswitch);
    end
  endtask

  task automatic test_early_release();
    req_a = 1'b0; req_b = 1'b0;
    tick();
    checks++;
    if ({busy, seg, nswitch} !== {1'b0, 8'h00, 8'd3}) begin
      errors++;
      $display("[TB] FAIL idle_after_release busy=%b seg=%h nsw=%0d exp busy=0 seg=00 nsw=3",
               busy, seg, nswitch);
    end
    req_a = 1'b1; sensor_a = 2'b10;
    tick();
    tick();
    checks++;
    if ({gnt_a, seg, nswitch} !== {1'b1, 8'h06, 8'd4}) begin
      errors++;
      $display("[TB] FAIL regrant_a gnt_a=%b seg=%h nsw=%0d exp gnt_a=1 seg=06 nsw=4",
               gnt_a, seg, nswitch);
    end
    req_a = 1'b0; req_b = 1'b1; sensor_b = 2'b11;
    tick();
    checks++;
    if ({gnt_a, gnt_b, seg, nswitch} !== {2'b01, 8'h5B, 8'd5}) begin
      errors++;
      $display("[TB] FAIL early_release gnt=%b%b seg=%h nsw=%0d exp gnt=01 seg=5b nsw=5",
               gnt_a, gnt_b, seg, nswitch);
    end
  endtask

  task automatic test_both_drop();
    tick();
    req_a = 1'b0; req_b = 1'b0;
    tick();
    checks++;
    if ({gnt_a, gnt_b, busy, seg, nswitch} !== {3'b000, 8'h00, 8'd5}) begin
      errors++;
      $display("[TB] FAIL both_drop gnt=%b%b busy=%b seg=%h nsw=%0d exp gnt=00 busy=0 seg=00 nsw=5",
               gnt_a, gnt_b, busy, seg, nswitch);
    end
  endtask

  task automatic test_async_reset();
    req_b = 1'b1; sensor_b = 2'b01;
    tick();
    checks++;
    if ({gnt_b, seg, nswitch} !== {1'b1, 8'h3F, 8'd6}) begin
      errors++;
      $display("[TB] FAIL pre_reset_gnt_b gnt_b=%b seg=%h nsw=%0d exp gnt_b=1 seg=3f nsw=6",
               gnt_b, seg, nswitch);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt_a, gnt_b, busy, seg, nswitch} !== {3'b000, 8'h00, 8'd0}) begin
      errors++;
      $display("[TB] FAIL async_clear gnt=%b%b busy=%b seg=%h nsw=%0d exp all zero",
               gnt_a, gnt_b, busy, seg, nswitch);
    end
    #1 rst_n = 1'b1;
    req_a = 1'b1; sensor_a = 2'b11;
    tick();
    checks++;
    if ({gnt_a, gnt_b, seg, nswitch} !== {2'b10, 8'h5B, 8'd1}) begin
      errors++;
      $display("[TB] FAIL post_reset_tie gnt=%b%b seg=%h nsw=%0d exp gnt=10 seg=5b nsw=1",
               gnt_a, gnt_b, seg, nswitch);
    end
    // Pulse again while A owns the display: tie must still go to A afterwards.
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    checks++;
    if ({gnt_a, gnt_b, nswitch} !== {2'b10, 8'd1}) begin
      errors++;
      $display("[TB] FAIL last_owner_reset gnt=%b%b nsw=%0d exp gnt=10 nsw=1",
               gnt_a, gnt_b, nswitch);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_seg_follow();
    test_early_release();
    test_both_drop();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_share_arbiter.md
Name: seg_share_arbiter

Overview:
- Shares the single 7-segment display (SEG) between two 2-bit sensor requesters, A and B.
- Round-robin arbitration with a minimum hold time per grant.
- The owner's sensor level is encoded to the 7-seg pattern and registered.
- Sits between the switch-decoded sensor sources and the SEG output in top; replaces the fixed sensor-to-SEG path and the A/B select mux with an arbitrated, clocked path.

Parameters:
- NBITS_SEG, 8, width of the segment pattern.
- HOLD_CYCLES, 4, minimum cycles a grant is held before it can be pre-empted by the other requester; legal range ≥1.
- CW, $clog2(HOLD_CYCLES+1), hold-counter width (derived, do not override).

Ports:
- clk_2  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_a  in  1  requester A wants the display; level-sensitive.
- req_b  in  1  requester B wants the display; level-sensitive.
- sensor_a  in  2  requester A level.
- sensor_b  in  2  requester B level.
- seg  out  NBITS_SEG  registered segment pattern.
- gnt_a  out  1  A owns the display (registered).
- gnt_b  out  1  B owns the display (registered).
- busy  out  1  gnt_a | gnt_b.
- nswitch  out  8  count of grant starts, wraps 255→0.

Behaviour:
- Reset (rst_n=0, async, any cycle including mid-grant):
  - state=IDLE, seg=8'h00, gnt_a=gnt_b=0, hold counter=0, nswitch=0, last_owner=B (so A wins the first tie).
  - All effects are immediate; the first decision is at the first rising clk_2 edge after rst_n rises.
- States: IDLE, GNT_A, GNT_B. gnt_a/gnt_b are one-hot-or-zero and decoded directly from the state register.
- IDLE:
  - req_a & req_b → grant the requester that is not last_owner.
  - Single request → grant it.
  - No request → stay.
  - Latency: grant is visible at the first edge after the request is sampled (1 cycle).
- GNT_X (X=A or B, Y=the other):
  - Hold counter resets to 0 on entry and increments each cycle while held, saturating at HOLD_CYCLES-1.
  - req_x=0 → release at next edge:
    - To GNT_Y if req_y=1, otherwise IDLE.
    - Early release before hold expiry is allowed.
  - req_x=1, req_y=1, counter==HOLD_CYCLES-1 → switch directly to GNT_Y at next edge; no IDLE bubble.
  - req_x=1, counter<HOLD_CYCLES-1 → stay, regardless of req_y.
  - req_x=1, req_y=0 → stay indefinitely; counter stays saturated.
- last_owner updates to X on every entry to GNT_X.
- nswitch increments by 1 on every entry to GNT_A or GNT_B, including a direct A↔B switch. Not incremented on entry to IDLE.
- seg is registered at the same edge as state, from the next-state owner's sensor sampled at that edge:
  - Encoding: 2'b00→8'h00, 2'b01→8'h3F, 2'b10→8'h06, 2'b11→8'h5B.
  - Next state IDLE → 8'h00.
  - Owner sensor changes while held → seg follows with 1-cycle latency.
- Simultaneous release of X and request by Y in the same cycle → GNT_Y next edge.
- Both requests drop in the same cycle → IDLE next edge.
- HOLD_CYCLES=1: counter is always at terminal; strict alternation each cycle while both request.

Decomposition:
- Shared package seg_pkg:
  - Type owner_t enum {OWN_NONE, OWN_A, OWN_B}.
  - Constants APAGADO=8'h00, ZERO=8'h3F, UM=8'h06, DOIS=8'h5B.
  - Function or type for the 2-bit level.
- Sub-module level_to_seg: combinational 2-bit level → 8-bit pattern, instantiated once on the muxed owner sensor.
- Arbiter FSM, hold counter, nswitch counter and output registers stay in seg_share_arbiter.

Test Plan (HOLD_CYCLES=4):
- Reset with req_a=1, sensor_a=2'b01 → seg=8'h00, gnt=00, nswitch=0 during reset. First edge after release: gnt_a=1, seg=8'h3F, nswitch=1.
- req_a=req_b=1 from IDLE after reset → A granted first. After exactly 4 cycles of gnt_a, gnt_b=1 the next cycle with no IDLE gap. Alternation A,B,A at a 4-cycle period; nswitch=1,2,3.
- GNT_A held, req_b=0, sensor_a steps 01→10→11 → seg 8'h3F→8'h06→8'h5B, each 1 cycle after the change; gnt_a stays 1 beyond 10 cycles.
- GNT_A at cycle 1 of hold, req_a drops while req_b=1 → gnt_b=1 next edge (early release); seg=encode(sensor_b).
- GNT_B held, both requests drop the same cycle → IDLE next edge: seg=8'h00, busy=0. nswitch unchanged.
- rst_n pulsed low mid-GNT_B for less than 1 cycle → outputs clear immediately, asynchronously. After release with both requesting, A is granted (last_owner reset to B).
